multicycle_control: RTL and testbench

- Multicycle MIPS control unit: Moore FSM sequencing each instruction over 3–5 states plus memory wait cycles.
- Generalises the single-cycle opcode decoder:
  - adds a memory-ready handshake for variable-latency memory
  - adds explicit illegal-opcode detection with optional halt
  - adds an instruction-retire strobe
  - parametrises the ALUOp width
- Sits between the instruction register (source of OPCODE) and the multicycle datapath muxes and enables.

---
 rtl/multicycle_control_pkg.sv | 68 ++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control_decode.sv | 86 ++++++++
 rtl/multicycle_control.sv | 84 ++++++++
 tb/tb_multicycle_control.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcodes, ALUOp codes and the internal control-word layout.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [2:0] ALU_SLT   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b111;

    // ALUOp is carried at its native 3-bit width and widened at the top level.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [2:0] aluop;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
        logic       illegal;
    } ctrl_word_t;

    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        logic [2:0] code;
        case (op)
            OP_ANDI: code = ALU_AND;
            OP_ORI:  code = ALU_OR;
            OP_SLTI: code = ALU_SLT;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control unit and the multicycle datapath: IR opcode,
// memory-ready handshake, and every mux select / enable the controller drives.
interface multicycle_control_if #(
    parameter int ALUOP_W = 3
);
    logic [5:0]         OPCODE;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemToReg;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUOp;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               RegWrite;
    logic               RegDst;
    logic               instr_done;
    logic               illegal;
    logic [3:0]         state;

    modport master (
        input  OPCODE, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               instr_done, illegal, state
    );

    modport slave (
        output OPCODE, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational Moore decoder: current state (plus mem_ready in the memory
// wait states and OPCODE in the immediate states) -> control word.
module mc_output_decode
    import multicycle_control_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = 2'b01;
                cw.aluop     = ALU_ADD;
                cw.ir_write  = mem_ready;
                cw.pc_write  = mem_ready;
            end
            S_DECODE: begin
                cw.alu_src_b = 2'b11;
                cw.aluop     = ALU_ADD;
            end
            S_MEMADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = 2'b10;
                cw.aluop     = ALU_ADD;
            end
            S_MEMRD: begin
                cw.mem_read = 1'b1;
                cw.iord     = 1'b1;
            end
            S_MEMWB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_MEMWR: begin
                cw.mem_write  = 1'b1;
                cw.iord       = 1'b1;
                cw.instr_done = mem_ready;
            end
            S_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.aluop     = ALU_RTYPE;
            end
            S_RWB: begin
                cw.reg_dst    = 1'b1;
                cw.reg_write  = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.aluop         = ALU_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_source     = 2'b01;
                cw.instr_done    = 1'b1;
            end
            S_JUMP: begin
                cw.pc_write   = 1'b1;
                cw.pc_source  = 2'b10;
                cw.instr_done = 1'b1;
            end
            S_IEXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = 2'b10;
                cw.aluop     = imm_aluop(opcode);
            end
            // ALU inputs stay driven so ALUOut is still valid during writeback.
            S_IWB: begin
                cw.alu_src_a  = 1'b1;
                cw.alu_src_b  = 2'b10;
                cw.aluop      = imm_aluop(opcode);
                cw.reg_write  = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                cw.illegal = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: state register and transition logic, with the
// control word decoded by mc_output_decode and blanked while rst is high.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W         = 3,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t cw_raw;
    ctrl_word_t cw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.OPCODE)
                    OP_LW, OP_SW:                      state_d = S_MEMADDR;
                    OP_R:                              state_d = S_EXEC;
                    OP_BEQ:                            state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
                    default:                           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADDR: state_d = (bus.OPCODE == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_d = S_RWB;
            S_RWB:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_IEXEC:   state_d = S_IWB;
            S_IWB:     state_d = S_FETCH;
            S_ILLEGAL: state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .opcode    (bus.OPCODE),
        .cw        (cw_raw)
    );

    // Blanking on rst itself (not just the registered state) keeps the
    // mem_ready-gated enables low from the instant reset rises.
    assign cw = rst ? '0 : cw_raw;

    assign bus.PCWrite     = cw.pc_write;
    assign bus.PCWriteCond = cw.pc_write_cond;
    assign bus.IorD        = cw.iord;
    assign bus.MemRead     = cw.mem_read;
    assign bus.MemWrite    = cw.mem_write;
    assign bus.IRWrite     = cw.ir_write;
    assign bus.MemToReg    = cw.mem_to_reg;
    assign bus.PCSource    = cw.pc_source;
    assign bus.ALUOp       = ALUOP_W'(cw.aluop);
    assign bus.ALUSrcA     = cw.alu_src_a;
    assign bus.ALUSrcB     = cw.alu_src_b;
    assign bus.RegWrite    = cw.reg_write;
    assign bus.RegDst      = cw.reg_dst;
    assign bus.instr_done  = cw.instr_done;
    assign bus.illegal     = cw.illegal;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a halting instance (ALUOP_W=3) and a
// non-halting instance (ALUOP_W=4) driven in lockstep from the same inputs.
module tb_multicycle_control;

    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADDR = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_EXEC    = 4'd6;
    localparam logic [3:0] ST_RWB     = 4'd7;
    localparam logic [3:0] ST_BRANCH  = 4'd8;
    localparam logic [3:0] ST_JUMP    = 4'd9;
    localparam logic [3:0] ST_IEXEC   = 4'd10;
    localparam logic [3:0] ST_IWB     = 4'd11;
    localparam logic [3:0] ST_ILLEGAL = 4'd12;

    // Field order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg
    //              PCSource ALUOp ALUSrcA ALUSrcB RegWrite RegDst instr_done illegal
    function automatic logic [18:0] mk(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic [1:0] pcs,
        input logic [2:0] alu, input logic srca, input logic [1:0] srcb,
        input logic rw, input logic rd, input logic done, input logic ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, pcs, alu, srca, srcb, rw, rd, done, ill};
    endfunction

    localparam logic [18:0] W_ZERO       = 19'd0;
    localparam logic [18:0] W_FETCH_WAIT = mk(0,0,0,1,0,0,0,2'b00,3'b011,0,2'b01,0,0,0,0);
    localparam logic [18:0] W_FETCH_RDY  = mk(1,0,0,1,0,1,0,2'b00,3'b011,0,2'b01,0,0,0,0);
    localparam logic [18:0] W_DECODE     = mk(0,0,0,0,0,0,0,2'b00,3'b011,0,2'b11,0,0,0,0);
    localparam logic [18:0] W_MEMADDR    = mk(0,0,0,0,0,0,0,2'b00,3'b011,1,2'b10,0,0,0,0);
    localparam logic [18:0] W_MEMRD      = mk(0,0,1,1,0,0,0,2'b00,3'b000,0,2'b00,0,0,0,0);
    localparam logic [18:0] W_MEMWB      = mk(0,0,0,0,0,0,1,2'b00,3'b000,0,2'b00,1,0,1,0);
    localparam logic [18:0] W_MEMWR_WAIT = mk(0,0,1,0,1,0,0,2'b00,3'b000,0,2'b00,0,0,0,0);
    localparam logic [18:0] W_MEMWR_RDY  = mk(0,0,1,0,1,0,0,2'b00,3'b000,0,2'b00,0,0,1,0);
    localparam logic [18:0] W_EXEC       = mk(0,0,0,0,0,0,0,2'b00,3'b010,1,2'b00,0,0,0,0);
    localparam logic [18:0] W_RWB        = mk(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,1,1,1,0);
    localparam logic [18:0] W_BRANCH     = mk(0,1,0,0,0,0,0,2'b01,3'b100,1,2'b00,0,0,1,0);
    localparam logic [18:0] W_JUMP       = mk(1,0,0,0,0,0,0,2'b10,3'b000,0,2'b00,0,0,1,0);
    localparam logic [18:0] W_IEXEC_ORI  = mk(0,0,0,0,0,0,0,2'b00,3'b101,1,2'b10,0,0,0,0);
    localparam logic [18:0] W_IWB_ORI    = mk(0,0,0,0,0,0,0,2'b00,3'b101,1,2'b10,1,0,1,0);
    localparam logic [18:0] W_IEXEC_SLTI = mk(0,0,0,0,0,0,0,2'b00,3'b001,1,2'b10,0,0,0,0);
    localparam logic [18:0] W_IWB_SLTI   = mk(0,0,0,0,0,0,0,2'b00,3'b001,1,2'b10,1,0,1,0);
    localparam logic [18:0] W_IEXEC_ANDI = mk(0,0,0,0,0,0,0,2'b00,3'b111,1,2'b10,0,0,0,0);
    localparam logic [18:0] W_IWB_ADDI   = mk(0,0,0,0,0,0,0,2'b00,3'b011,1,2'b10,1,0,1,0);
    localparam logic [18:0] W_ILLEGAL    = mk(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,0,0,0,1);

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   irw_count;

    multicycle_control_if #(.ALUOP_W(3)) bus0 ();
    multicycle_control_if #(.ALUOP_W(4)) bus1 ();

    multicycle_control #(.ALUOP_W(3), .HALT_ON_ILLEGAL(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    multicycle_control #(.ALUOP_W(4), .HALT_ON_ILLEGAL(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    assign bus1.OPCODE    = bus0.OPCODE;
    assign bus1.mem_ready = bus0.mem_ready;

    logic [18:0] obs0;
    logic [18:0] obs1;
    assign obs0 = {bus0.PCWrite, bus0.PCWriteCond, bus0.IorD, bus0.MemRead, bus0.MemWrite,
                   bus0.IRWrite, bus0.MemToReg, bus0.PCSource, bus0.ALUOp, bus0.ALUSrcA,
                   bus0.ALUSrcB, bus0.RegWrite, bus0.RegDst, bus0.instr_done, bus0.illegal};
    assign obs1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.IorD, bus1.MemRead, bus1.MemWrite,
                   bus1.IRWrite, bus1.MemToReg, bus1.PCSource, bus1.ALUOp[2:0], bus1.ALUSrcA,
                   bus1.ALUSrcB, bus1.RegWrite, bus1.RegDst, bus1.instr_done, bus1.illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk4(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic chk19(input string tag, input logic [18:0] observed, input logic [18:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One clock of the halting instance: drive mem_ready, check state and
    // control word mid-cycle, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic mr, input logic [3:0] es, input logic [18:0] ew);
        bus0.mem_ready = mr;
        #1;
        chk4({tag, ".state"}, bus0.state, es);
        chk19({tag, ".ctrl"}, obs0, ew);
        if (bus0.IRWrite === 1'b1) irw_count++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        irw_count = 0;
        rst            = 1'b1;
        bus0.OPCODE    = 6'b000000;
        bus0.mem_ready = 1'b1;

        // Reset held in FETCH with mem_ready high: everything must be low.
        repeat (2) @(posedge clk);
        #1;
        chk4("rst.state", bus0.state, ST_FETCH);
        chk19("rst.ctrl", obs0, W_ZERO);
        chk19("rst.ctrl1", obs1, W_ZERO);
        @(negedge clk);
        rst = 1'b0;

        // R-type, mem_ready always high: 4 cycles.
        step("rt.fetch",  1'b1, ST_FETCH,  W_FETCH_RDY);
        step("rt.decode", 1'b1, ST_DECODE, W_DECODE);
        step("rt.exec",   1'b1, ST_EXEC,   W_EXEC);
        step("rt.rwb",    1'b1, ST_RWB,    W_RWB);

        // lw with 2 FETCH waits and 3 MEMRD waits: 10 cycles.
        bus0.OPCODE = 6'b100011;
        irw_count   = 0;
        step("lw.fwait0", 1'b0, ST_FETCH,   W_FETCH_WAIT);
        step("lw.fwait1", 1'b0, ST_FETCH,   W_FETCH_WAIT);
        step("lw.fetch",  1'b1, ST_FETCH,   W_FETCH_RDY);
        step("lw.decode", 1'b0, ST_DECODE,  W_DECODE);
        step("lw.maddr",  1'b0, ST_MEMADDR, W_MEMADDR);
        step("lw.rwait0", 1'b0, ST_MEMRD,   W_MEMRD);
        step("lw.rwait1", 1'b0, ST_MEMRD,   W_MEMRD);
        step("lw.rwait2", 1'b0, ST_MEMRD,   W_MEMRD);
        step("lw.memrd",  1'b1, ST_MEMRD,   W_MEMRD);
        step("lw.memwb",  1'b0, ST_MEMWB,   W_MEMWB);
        chk4("lw.irwrite_pulses", 4'(irw_count), 4'd1);

        // sw with one write wait: 5 cycles, instr_done only on the ready cycle.
        bus0.OPCODE = 6'b101011;
        step("sw.fetch",  1'b1, ST_FETCH,   W_FETCH_RDY);
        step("sw.decode", 1'b1, ST_DECODE,  W_DECODE);
        step("sw.maddr",  1'b1, ST_MEMADDR, W_MEMADDR);
        step("sw.wwait",  1'b0, ST_MEMWR,   W_MEMWR_WAIT);
        step("sw.memwr",  1'b1, ST_MEMWR,   W_MEMWR_RDY);

        // beq then j back to back, 3 cycles each.
        bus0.OPCODE = 6'b000100;
        step("beq.fetch",  1'b1, ST_FETCH,  W_FETCH_RDY);
        step("beq.decode", 1'b1, ST_DECODE, W_DECODE);
        chk4("beq.aluop_w4", bus1.ALUOp, 4'b0100);
        step("beq.branch", 1'b1, ST_BRANCH, W_BRANCH);
        bus0.OPCODE = 6'b000010;
        step("j.fetch",  1'b1, ST_FETCH,  W_FETCH_RDY);
        step("j.decode", 1'b1, ST_DECODE, W_DECODE);
        step("j.jump",   1'b0, ST_JUMP,   W_JUMP);

        // Immediate ops: ALUOp held through IEXEC and IWB.
        bus0.OPCODE = 6'b001101;
        step("ori.fetch",  1'b1, ST_FETCH,  W_FETCH_RDY);
        step("ori.decode", 1'b1, ST_DECODE, W_DECODE);
        step("ori.iexec",  1'b1, ST_IEXEC,  W_IEXEC_ORI);
        step("ori.iwb",    1'b1, ST_IWB,    W_IWB_ORI);
        bus0.OPCODE = 6'b001010;
        step("slti.fetch",  1'b1, ST_FETCH,  W_FETCH_RDY);
        step("slti.decode", 1'b1, ST_DECODE, W_DECODE);
        step("slti.iexec",  1'b1, ST_IEXEC,  W_IEXEC_SLTI);
        step("slti.iwb",    1'b1, ST_IWB,    W_IWB_SLTI);
        bus0.OPCODE = 6'b001100;
        step("andi.fetch",  1'b1, ST_FETCH,  W_FETCH_RDY);
        step("andi.decode", 1'b1, ST_DECODE, W_DECODE);
        step("andi.iexec",  1'b1, ST_IEXEC,  W_IEXEC_ANDI);
        bus0.OPCODE = 6'b001000;
        step("andi.iwb_addi_opcode", 1'b1, ST_IWB, W_IWB_ADDI);

        // Illegal opcode: halting instance absorbs, the other returns to FETCH.
        bus0.OPCODE = 6'b111111;
        step("ill.fetch",  1'b1, ST_FETCH,  W_FETCH_RDY);
        step("ill.decode", 1'b1, ST_DECODE, W_DECODE);
        #1;
        chk4("ill.nohalt_state", bus1.state, ST_ILLEGAL);
        chk19("ill.nohalt_ctrl", obs1, W_ILLEGAL);
        step("ill.hold0", 1'b1, ST_ILLEGAL, W_ILLEGAL);
        chk4("ill.nohalt_back", bus1.state, ST_FETCH);
        for (int i = 1; i < 20; i++) begin
            step("ill.hold", 1'(i), ST_ILLEGAL, W_ILLEGAL);
        end

        // Asynchronous reset clears the halt immediately.
        bus0.mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk4("ill.rst_state", bus0.state, ST_FETCH);
        chk19("ill.rst_ctrl", obs0, W_ZERO);
        @(negedge clk);
        rst = 1'b0;

        // Abort a store during its ready cycle: MemWrite must vanish with rst.
        bus0.OPCODE = 6'b101011;
        step("abort.fetch",  1'b1, ST_FETCH,   W_FETCH_RDY);
        step("abort.decode", 1'b1, ST_DECODE,  W_DECODE);
        step("abort.maddr",  1'b1, ST_MEMADDR, W_MEMADDR);
        bus0.mem_ready = 1'b1;
        #1;
        chk19("abort.pre_ctrl", obs0, W_MEMWR_RDY);
        rst = 1'b1;
        #1;
        chk4("abort.state", bus0.state, ST_FETCH);
        chk19("abort.ctrl", obs0, W_ZERO);
        chk19("abort.ctrl1", obs1, W_ZERO);
        bus0.OPCODE = 6'b000000;
        @(negedge clk);
        rst = 1'b0;

        step("post.fetch",  1'b1, ST_FETCH,  W_FETCH_RDY);
        step("post.decode", 1'b1, ST_DECODE, W_DECODE);
        step("post.exec",   1'b1, ST_EXEC,   W_EXEC);
        step("post.rwb",    1'b1, ST_RWB,    W_RWB);
        step("post.fetch2", 1'b0, ST_FETCH,  W_FETCH_WAIT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
